// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers, with per-register write strobes.
// Define AXIL_SLV_ERR_EN to answer out-of-range accesses with SLVERR. Without it, every access answers OKAY.
module axil_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  output logic                           s_axi_awready,
  input  logic                           s_axi_wvalid,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  output logic                           s_axi_wready,
  output logic                           s_axi_bvalid,
  output logic [1:0]                     s_axi_bresp,
  input  logic                           s_axi_bready,
  input  logic                           s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  output logic                           s_axi_arready,
  output logic                           s_axi_rvalid,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < NUM_REGS_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic                  r_aw_held, r_w_held, r_bvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  rstate_t               r_rstate, w_rstate_next;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data, w_rd_data;
  logic                  w_wr_hit, w_rd_hit;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic [1:0]            w_wr_resp, w_rd_resp;
  logic [NUM_REGS-1:0]   w_wr_sel;

  assign s_axi_awready = !reset && !r_aw_held && !r_bvalid;
  assign s_axi_wready  = !reset && !r_w_held && !r_bvalid;
  assign s_axi_arready = !reset && (r_rstate == R_IDLE);
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign wr_pulse      = r_wr_pulse;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit on the edge that completes the second half; bypass the holding regs for that half.
  assign w_commit  = (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held);
  assign w_wr_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
  assign w_wr_data = w_w_hs ? s_axi_wdata : r_wdata;
  assign w_wr_hit  = addr_in_range(w_wr_addr);
  assign w_wr_idx  = addr_idx(w_wr_addr);
  assign w_rd_hit  = addr_in_range(s_axi_araddr);
  assign w_rd_idx  = addr_idx(s_axi_araddr);
  assign w_rd_data = w_rd_hit ? r_regs[w_rd_idx] : '0;

`ifdef AXIL_SLV_ERR_EN
  assign w_wr_resp = w_wr_hit ? 2'b00 : 2'b10;
  assign w_rd_resp = w_rd_hit ? 2'b00 : 2'b10;
`else
  assign w_wr_resp = 2'b00;
  assign w_rd_resp = 2'b00;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign w_wr_sel[gi] = w_commit && w_wr_hit && (w_wr_idx == IDX_W'(gi));
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_resp;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
      end
      if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        r_regs[i]     <= '0;
        r_wr_pulse[i] <= 1'b0;
      end else begin
        r_wr_pulse[i] <= w_wr_sel[i];
        if (w_wr_sel[i]) r_regs[i] <= w_wr_data;
      end
    end
  end

  // Read path: rdata captured at the AR edge, so a same-edge write is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi_arvalid) w_rstate_next = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite responder that terminates the slave side of the AXI-Lite interconnect and exposes a bank of NUM_REGS read/write control registers to the peripheral subsystem. It accepts the write address and write data channels independently, in either order, and returns one B response per write. It serves reads with one-cycle latency. Register contents and per-register write strobes drive downstream peripheral logic.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data and register width
- NUM_REGS, 8, number of registers (≥1); register i lives at BASE_ADDR + 4·i
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awready  out  1  write address ready
- s_axi_wvalid  in  1  write data valid
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wready  out  1  write data ready
- s_axi_bvalid  out  1  write response valid
- s_axi_bresp  out  2  write response
- s_axi_bready  in  1  write response ready
- s_axi_arvalid  in  1  read address valid
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arready  out  1  read address ready
- s_axi_rvalid  out  1  read data valid
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rready  in  1  read data ready
- reg_q  out  NUM_REGS·DATA_WIDTH  register contents; register i is at bits [i·DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  NUM_REGS  one-cycle strobe for each register that was written

## Operation
- Address decode: off = addr − BASE_ADDR. The access is in range iff addr ≥ BASE_ADDR and (off >> 2) < NUM_REGS. addr[1:0] is ignored.
- Write path: holds two flags, aw_held and w_held.
  - awready = !reset && !aw_held && !bvalid
  - wready = !reset && !w_held && !bvalid
  - A handshake on a channel captures that channel's address or data and sets its flag.
- Write commit: occurs at the edge where the second of the two handshakes completes. If both handshakes complete in the same cycle, the commit occurs at that edge.
  - At commit: the in-range register is updated, both flags are cleared, and bvalid is set.
  - bvalid holds until bvalid && bready. While bvalid=1, no new AW or W is accepted.
- Read path: states R_IDLE and R_DATA.
  - arready = !reset && state==R_IDLE.
  - On an AR handshake, rdata is registered from the decoded register and the block moves to R_DATA with rvalid=1.
  - The block returns to R_IDLE on rvalid && rready.
  - rdata is stable while rvalid=1.
- The read and write paths are fully independent and may be active simultaneously.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=2'b00, rvalid=0, rdata=0, rresp=2'b00, reg_q=0, wr_pulse=0. Held address and held data are discarded.
- Reset mid-transaction: pending B/R responses are dropped. All readies are 1 in the first cycle after reset deasserts.
- Write latency: commit at edge N. bvalid=1, the reg_q update and wr_pulse[i]=1 are all visible in cycle N+1. wr_pulse lasts exactly one cycle.
- Best-case write throughput is one write per 2 cycles. The earliest next AW/W acceptance is the cycle in which bvalid && bready occurs, plus one.
- Read latency: AR handshake at edge N gives rvalid=1 in cycle N+1. Best-case throughput is one read per 2 cycles.
- Same-edge read and write commit to the same register: the read returns the pre-write value.
- Out-of-range writes change no register and produce no wr_pulse. Out-of-range reads return rdata=0.

## Configuration
- AXIL_SLV_ERR_EN defined: out-of-range accesses respond bresp/rresp=2'b10 (SLVERR).
- AXIL_SLV_ERR_EN undefined: all responses are 2'b00 (OKAY). Data behaviour is identical in both builds.

## Test plan
- Simultaneous AW+W: addr=BASE+8, data=32'hDEAD_BEEF, bready=1 → bvalid in the next cycle, bresp=0, reg_q[2]=32'hDEAD_BEEF, wr_pulse=8'b0000_0100 for one cycle.
- W issued 3 cycles before AW: addr=BASE+4, data=32'h1234 → wready then drops and awready stays 1; commit on the AW cycle; reg_q[1]=32'h1234.
- bready held 0 for 5 cycles → bvalid stays 1 and awready/wready stay 0 for those cycles; a second AW+W is accepted only after B completes.
- Read of BASE+8 after the first test, rready held 0 for 4 cycles → rvalid the cycle after AR; rdata=32'hDEAD_BEEF stable; arready=0 until rready.
- Write to BASE+4·NUM_REGS plus a read of the same address → no reg_q change and no wr_pulse; rdata=0; resp=2'b10 with AXIL_SLV_ERR_EN, 2'b00 without.
- reset asserted while bvalid=1 and rvalid=1 → next cycle all valids=0, reg_q=0, readies=1 once reset is released.
